// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the E stage.
// Accepts decoded MD ops, launches them on an external iterative core via a
// start/done handshake, enforces a minimum busy latency, owns committed HI/LO
// and raises the D-stage stall for MD-dependent instructions.
// Optional feature macro: MD_MADD_EN enables MADD/MSUB (ops 9/10) with an
// accumulator snapshot on core_acc; when undefined those ops decode as NONE.
module md_ctrl #(
  parameter int unsigned MUL_CYC = 5,   // 2..15
  parameter int unsigned DIV_CYC = 10   // 2..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        core_start,
  output logic [3:0]  core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [63:0] core_acc,
  input  logic        core_done,
  input  logic [31:0] core_hi,
  input  logic [31:0] core_lo,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [31:0] e_hl_data,
  output logic        md_busy,
  output logic        md_stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [3:0] MUL_LAT = 4'(MUL_CYC);
  localparam logic [3:0] DIV_LAT = 4'(DIV_CYC);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        done_seen;    // core result already captured in res_hi/res_lo
  logic        skip_commit;  // divide by zero: leave HI/LO untouched
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        is_mul;
  logic        is_div;
  logic        launch_op;

  // Decode which E-stage ops occupy the MD resource.
  always_comb begin
    is_mul = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
`ifdef MD_MADD_EN
    is_mul = is_mul || (e_md_op == OP_MADD) || (e_md_op == OP_MSUB);
`endif
    is_div    = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);
    launch_op = is_mul || is_div;
  end

  assign core_start = (state == ST_LAUNCH);
  assign md_busy    = (state != ST_IDLE);
  assign md_stall   = d_md_use && (md_busy || (e_valid && launch_op));

  // Moves-from always read the committed registers, never an in-flight result.
  always_comb begin
    e_hl_data = 32'h0;
    if (e_md_op == OP_MFHI)      e_hl_data = hi_q;
    else if (e_md_op == OP_MFLO) e_hl_data = lo_q;
  end

`ifdef MD_MADD_EN
  logic [63:0] acc_q;
  assign core_acc = acc_q;

  // Snapshot {HI,LO} at accept so the core sees the pre-op accumulator.
  always_ff @(posedge clk) begin
    if (rst)
      acc_q <= 64'h0;
    else if (state == ST_IDLE && e_valid && is_mul)
      acc_q <= {hi_q, lo_q};
  end
`else
  assign core_acc = 64'h0;
`endif

  // Sequencer: accept, launch, count minimum latency, commit on done.
  // NOTE: every register here, including the result holding regs, is reset
  // so an aborted operation leaves no stale result to commit later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      done_seen   <= 1'b0;
      skip_commit <= 1'b0;
      res_hi      <= 32'h0;
      res_lo      <= 32'h0;
      core_op     <= 4'd0;
      core_a      <= 32'h0;
      core_b      <= 32'h0;
      hi_q        <= 32'h0;
      lo_q        <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // the values sampled at this edge, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (e_valid) begin
            if (launch_op) begin
              core_op     <= e_md_op;
              core_a      <= e_rs;
              core_b      <= e_rt;
              cnt         <= is_div ? DIV_LAT : MUL_LAT;
              done_seen   <= 1'b0;
              skip_commit <= 1'b0;
              if (is_div && e_rt == 32'h0) begin
                // Divide by zero: no core launch, just serve the latency.
                state       <= ST_RUN;
                done_seen   <= 1'b1;
                skip_commit <= 1'b1;
              end else begin
                state <= ST_LAUNCH;
              end
            end else if (e_md_op == OP_MTHI) begin
              hi_q <= e_rs;
            end else if (e_md_op == OP_MTLO) begin
              lo_q <= e_rs;
            end
          end
        end

        ST_LAUNCH: begin
          cnt   <= cnt - 4'd1;
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (core_done && !done_seen) begin
            done_seen <= 1'b1;
            res_hi    <= core_hi;
            res_lo    <= core_lo;
          end
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else if (done_seen || core_done) begin
            if (!skip_commit) begin
              hi_q <= done_seen ? res_hi : core_hi;
              lo_q <= done_seen ? res_lo : core_lo;
            end
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed self-checking bench for md_ctrl (default parameters).
module tb_md_ctrl;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_use;
  logic        core_start;
  logic [3:0]  core_op;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [63:0] core_acc;
  logic        core_done;
  logic [31:0] core_hi;
  logic [31:0] core_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] e_hl_data;
  logic        md_busy;
  logic        md_stall;

  int n_cmp = 0;
  int n_bad = 0;

  md_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst(rst),
    .e_valid(e_valid), .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt),
    .d_md_use(d_md_use),
    .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_acc(core_acc), .core_done(core_done), .core_hi(core_hi), .core_lo(core_lo),
    .hi_q(hi_q), .lo_q(lo_q), .e_hl_data(e_hl_data),
    .md_busy(md_busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    e_valid = 1'b0; e_md_op = OP_NONE; e_rs = 32'h0; e_rt = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle_inputs(); d_md_use = 1'b0;
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({core_start, md_busy, md_stall} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got start/busy/stall=%b expected 000", {core_start, md_busy, md_stall});
    end
    n_cmp++;
    if ({hi_q, lo_q, e_hl_data} !== 96'h0) begin
      n_bad++; $display("FAIL reset_hilo: got hi=%h lo=%h hl=%h expected 0", hi_q, lo_q, e_hl_data);
    end
    n_cmp++;
    if ({core_op, core_a, core_b, core_acc} !== 132'h0) begin
      n_bad++; $display("FAIL reset_core: got op=%h a=%h b=%h acc=%h expected 0", core_op, core_a, core_b, core_acc);
    end
  endtask

  task automatic test_mthi_mfhi;
    e_valid = 1'b1; e_md_op = OP_MTHI; e_rs = 32'h12345678;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin
      n_bad++; $display("FAIL mthi_busy: got %b expected 0", md_busy);
    end
    tick();
    e_md_op = OP_MFHI; e_rs = 32'h0;
    #1;
    n_cmp++;
    if (e_hl_data !== 32'h12345678 || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL mfhi_data: got %h busy=%b expected 12345678 busy=0", e_hl_data, md_busy);
    end
    e_md_op = OP_MFLO;
    #1;
    n_cmp++;
    if (e_hl_data !== 32'h0) begin
      n_bad++; $display("FAIL mflo_data: got %h expected 0", e_hl_data);
    end
    e_md_op = OP_MULT; e_valid = 1'b0;
    #1;
    n_cmp++;
    if (e_hl_data !== 32'h0) begin
      n_bad++; $display("FAIL hl_other_op: got %h expected 0", e_hl_data);
    end
    idle_inputs();
    tick();
  endtask

  // MULT FFFFFFFF x 2, early done at T+2; commit must wait until T+5.
  task automatic test_mult;
    e_valid = 1'b1; e_md_op = OP_MULT; e_rs = 32'hFFFF_FFFF; e_rt = 32'h2;
    tick();                                     // T+1
    idle_inputs();
    n_cmp++;
    if (core_start !== 1'b1 || md_busy !== 1'b1) begin
      n_bad++; $display("FAIL mult_launch: got start=%b busy=%b expected 1 1", core_start, md_busy);
    end
    n_cmp++;
    if (core_op !== OP_MULT || core_a !== 32'hFFFF_FFFF || core_b !== 32'h2) begin
      n_bad++; $display("FAIL mult_latch: got op=%h a=%h b=%h expected 1 ffffffff 2", core_op, core_a, core_b);
    end
    tick();                                     // T+2
    n_cmp++;
    if (core_start !== 1'b0) begin
      n_bad++; $display("FAIL mult_start_once: got %b expected 0", core_start);
    end
    core_done = 1'b1; core_hi = 32'hFFFF_FFFF; core_lo = 32'hFFFF_FFFE;
    tick();                                     // T+3
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    for (int k = 3; k <= 5; k++) begin
      n_cmp++;
      if (md_busy !== 1'b1 || core_start !== 1'b0 || hi_q !== 32'h12345678) begin
        n_bad++; $display("FAIL mult_busy_T+%0d: got busy=%b start=%b hi=%h expected 1 0 12345678", k, md_busy, core_start, hi_q);
      end
      tick();
    end                                         // T+6
    n_cmp++;
    if (md_busy !== 1'b0 || hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL mult_commit: got busy=%b hi=%h lo=%h expected 0 ffffffff fffffffe", md_busy, hi_q, lo_q);
    end
  endtask

  // DIVU 7/2 with a late done at T+14.
  task automatic test_divu;
    int busy_cnt;
    busy_cnt = 0;
    e_valid = 1'b1; e_md_op = OP_DIVU; e_rs = 32'd7; e_rt = 32'd2;
    tick();                                     // T+1
    idle_inputs();
    n_cmp++;
    if (core_start !== 1'b1) begin
      n_bad++; $display("FAIL divu_launch: got %b expected 1", core_start);
    end
    for (int k = 1; k <= 13; k++) begin
      if (md_busy === 1'b1) busy_cnt++;
      tick();
    end                                         // T+14
    core_done = 1'b1; core_hi = 32'd1; core_lo = 32'd3;
    n_cmp++;
    if (busy_cnt !== 13 || md_busy !== 1'b1 || hi_q !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL divu_wait: got busy_cycles=%0d busy=%b hi=%h expected 13 1 ffffffff", busy_cnt, md_busy, hi_q);
    end
    tick();                                     // T+15
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    n_cmp++;
    if (md_busy !== 1'b0 || hi_q !== 32'd1 || lo_q !== 32'd3) begin
      n_bad++; $display("FAIL divu_commit: got busy=%b hi=%h lo=%h expected 0 1 3", md_busy, hi_q, lo_q);
    end
  endtask

  task automatic test_div_zero;
    int busy_cnt;
    int start_cnt;
    busy_cnt = 0; start_cnt = 0;
    e_valid = 1'b1; e_md_op = OP_MTHI; e_rs = 32'hA;
    tick();
    e_md_op = OP_MTLO; e_rs = 32'hB;
    tick();
    e_md_op = OP_DIV; e_rs = 32'd9; e_rt = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      idle_inputs();
      if (md_busy === 1'b1) busy_cnt++;
      if (core_start === 1'b1) start_cnt++;
    end
    n_cmp++;
    if (busy_cnt !== 10 || start_cnt !== 0) begin
      n_bad++; $display("FAIL div0_timing: got busy_cycles=%0d starts=%0d expected 10 0", busy_cnt, start_cnt);
    end
    n_cmp++;
    if (hi_q !== 32'hA || lo_q !== 32'hB || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL div0_hilo: got hi=%h lo=%h busy=%b expected a b 0", hi_q, lo_q, md_busy);
    end
  endtask

  task automatic test_stall;
    d_md_use = 1'b1;
    e_valid = 1'b1; e_md_op = OP_MULT; e_rs = 32'h3; e_rt = 32'h4;
    #1;
    n_cmp++;
    if (md_stall !== 1'b1 || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_T: got stall=%b busy=%b expected 1 0", md_stall, md_busy);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      idle_inputs();
      core_done = (k == 3); core_hi = (k == 3) ? 32'h11 : 32'h0; core_lo = (k == 3) ? 32'h22 : 32'h0;
      #1;
      n_cmp++;
      if (md_stall !== 1'b1) begin
        n_bad++; $display("FAIL stall_T+%0d: got %b expected 1", k, md_stall);
      end
    end
    tick();                                     // T+6
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    #1;
    n_cmp++;
    if (md_stall !== 1'b0 || hi_q !== 32'h11 || lo_q !== 32'h22) begin
      n_bad++; $display("FAIL stall_release: got stall=%b hi=%h lo=%h expected 0 11 22", md_stall, hi_q, lo_q);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_reset_abort;
    e_valid = 1'b1; e_md_op = OP_MULT; e_rs = 32'h5; e_rt = 32'h6;
    tick();                                     // T+1
    idle_inputs();
    tick();                                     // T+2
    tick();                                     // T+3
    rst = 1'b1;
    tick();                                     // T+4
    rst = 1'b0;
    n_cmp++;
    if (md_busy !== 1'b0 || core_start !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
      n_bad++; $display("FAIL abort_state: got busy=%b start=%b hi=%h lo=%h expected 0 0 0 0", md_busy, core_start, hi_q, lo_q);
    end
    core_done = 1'b1; core_hi = 32'hDEAD_BEEF; core_lo = 32'hCAFE_F00D;
    tick();
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    tick();
    n_cmp++;
    if (md_busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
      n_bad++; $display("FAIL abort_late_done: got busy=%b hi=%h lo=%h expected 0 0 0", md_busy, hi_q, lo_q);
    end
  endtask

  task automatic test_madd;
    e_valid = 1'b1; e_md_op = OP_MTHI; e_rs = 32'h5;
    tick();
    e_md_op = OP_MTLO; e_rs = 32'h6;
    tick();
    d_md_use = 1'b1;
    e_md_op = OP_MADD; e_rs = 32'h7; e_rt = 32'h8;
    #1;
`ifdef MD_MADD_EN
    n_cmp++;
    if (md_stall !== 1'b1) begin
      n_bad++; $display("FAIL madd_stall: got %b expected 1", md_stall);
    end
    tick();
    idle_inputs(); d_md_use = 1'b0;
    n_cmp++;
    if (core_start !== 1'b1 || core_acc !== 64'h0000_0005_0000_0006) begin
      n_bad++; $display("FAIL madd_acc: got start=%b acc=%h expected 1 0000000500000006", core_start, core_acc);
    end
    tick();
    core_done = 1'b1; core_hi = 32'h5; core_lo = 32'h3E;
    tick();
    core_done = 1'b0; core_hi = 32'h0; core_lo = 32'h0;
    tick(); tick(); tick();                     // T+6
    n_cmp++;
    if (md_busy !== 1'b0 || hi_q !== 32'h5 || lo_q !== 32'h3E) begin
      n_bad++; $display("FAIL madd_commit: got busy=%b hi=%h lo=%h expected 0 5 3e", md_busy, hi_q, lo_q);
    end
`else
    n_cmp++;
    if (md_stall !== 1'b0) begin
      n_bad++; $display("FAIL madd_off_stall: got %b expected 0", md_stall);
    end
    tick();
    idle_inputs(); d_md_use = 1'b0;
    n_cmp++;
    if (core_start !== 1'b0 || md_busy !== 1'b0 || core_acc !== 64'h0) begin
      n_bad++; $display("FAIL madd_off_launch: got start=%b busy=%b acc=%h expected 0 0 0", core_start, md_busy, core_acc);
    end
    n_cmp++;
    if (hi_q !== 32'h5 || lo_q !== 32'h6) begin
      n_bad++; $display("FAIL madd_off_hilo: got hi=%h lo=%h expected 5 6", hi_q, lo_q);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mthi_mfhi();
    test_mult();
    test_divu();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_madd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
